spawn_scheduler: RTL and testbench
==================================

Name: spawn_scheduler

Overview:
- Consumes the free-running 16-bit LFSR value from the random generator and turns it into timed, bounded spawn events for the teeter game logic.
- Waits a random interval, then draws a uniformly distributed position in [0, POS_LIMIT) by rejection sampling.
- Offers the position on a valid/ready handshake to the downstream game-state block.

Parameters:
- MIN_INTERVAL, 16'd32: minimum spawn interval in cycles.
- INTERVAL_W, 8: number of random low bits added to MIN_INTERVAL; legal range 1..15.
- POS_W, 4: position width.
- POS_LIMIT, 12: number of legal positions. Constraint: 2^(POS_W-1) < POS_LIMIT <= 2^POS_W.
- MAX_TRIES, 4: rejection attempts before fallback; must be >= 1.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_enable  in  1  game running; arms the scheduler
- i_rand_value  in  16  random word from the LFSR; a new value every cycle
- o_spawn_valid  out  1  spawn offer valid
- i_spawn_ready  in  1  downstream accepts the offer
- o_spawn_pos  out  POS_W  spawn position; stable while o_spawn_valid is high
- o_waiting  out  1  high while the interval counter is running

Behaviour:
- Clock and reset: one clock, i_clk; reset i_rst is synchronous and active-high.
- Reset values: state IDLE, o_spawn_valid=0, o_spawn_pos=0, o_waiting=0, counter=0, tries=0.
- Reset has priority in every state. Asserting i_rst during OFFER drops valid at the next edge with no handshake.
- IDLE: valid=0. If i_enable=1, go to LOAD next cycle.
- LOAD (1 cycle):
  - counter <= MIN_INTERVAL + zero-extended i_rand_value[INTERVAL_W-1:0].
  - Addition is 16-bit and must not overflow; the parameter check guarantees this.
  - tries <= 0. Go to COUNT.
- COUNT:
  - o_waiting=1. Counter decrements each cycle.
  - When counter==0, go to PICK.
  - If i_enable=0 in any COUNT cycle, go to IDLE and discard the counter.
  - PICK therefore starts exactly N+1 cycles after the LOAD cycle, where N is the loaded value.
- PICK (one sample per cycle):
  - cand = i_rand_value[15 -: POS_W].
  - If cand < POS_LIMIT: o_spawn_pos <= cand, go to OFFER.
  - Else if tries == MAX_TRIES-1: o_spawn_pos <= cand - POS_LIMIT, go to OFFER. This fallback always lands in range given the parameter constraint.
  - Else tries <= tries+1 and stay in PICK.
  - i_enable is ignored in PICK.
- OFFER:
  - o_spawn_valid=1; o_spawn_pos is held.
  - Valid never drops without a handshake, except on reset.
  - On valid & ready: go to LOAD if i_enable=1, else IDLE. Valid is 0 in the following cycle.
  - Deasserting i_enable during OFFER does not withdraw the offer.
- Throughput: at most one spawn per MIN_INTERVAL+3 cycles. There is no combinational path from i_spawn_ready to o_spawn_valid.
- Interval arithmetic: counter is 16 bits. The elaboration check is MIN_INTERVAL + 2^INTERVAL_W - 1 <= 16'hFFFF; violating it is a fatal elaboration error.

Decomposition:
- Shared package spawn_pkg holds:
  - the state encodings IDLE/LOAD/COUNT/PICK/OFFER as 3-bit localparams;
  - the elaboration-check helper for interval width and POS_LIMIT range.
- One natural sub-module, rand_range_sampler. It is combinational, with a registered tries counter: it takes i_rand_value, tries and a start/step control, and returns cand_ok, cand and fallback.
- The top level owns the FSM, interval counter and output registers.

Test Plan:
(Params MIN_INTERVAL=4, INTERVAL_W=3, POS_W=4, POS_LIMIT=12, MAX_TRIES=4; the bench drives i_rand_value directly.)
1. Basic timing: release reset, i_enable=1, rand=16'h0003 in the LOAD cycle -> N=7; PICK starts 8 cycles after LOAD. Rand=16'h5000 in PICK -> next cycle o_spawn_valid=1, o_spawn_pos=5; o_waiting high for exactly 8 cycles.
2. Rejection: PICK samples with upper nibble 0xE, 0xD, 0x3 -> o_spawn_pos=3, valid asserts after the 3rd PICK cycle.
3. Fallback: samples 0xF, 0xC, 0xD, 0xE -> o_spawn_pos=2 (14-12); valid after exactly 4 PICK cycles.
4. Backpressure: hold i_spawn_ready=0 for 10 cycles in OFFER -> valid stays 1 and pos stays constant. Ready=1 -> exactly one transfer, valid=0 next cycle, LOAD entered.
5. Enable handling:
   - Drop i_enable mid-COUNT -> IDLE, no spawn, o_waiting=0 next cycle.
   - Drop i_enable in OFFER -> offer held until ready, then IDLE (no new LOAD).
6. Reset in OFFER: i_rst=1 for one cycle -> next edge o_spawn_valid=0, o_spawn_pos=0, state IDLE. With i_enable=1 after release -> LOAD one cycle later.

Source files
------------

// File: rtl/spawn_pkg.sv
// spawn_pkg: shared definitions for the spawn scheduler.
//   state_t   - scheduler FSM state encoding (3 bits)
//   params_ok - elaboration-time legality check for the scheduler parameters
package spawn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_COUNT = 3'd2,
    ST_PICK  = 3'd3,
    ST_OFFER = 3'd4
  } state_t;

  // Interval must fit the 16-bit counter without wrapping; POS_LIMIT must be
  // above half the position range so a single subtraction always folds an
  // out-of-range candidate back into [0, POS_LIMIT).
  function automatic bit params_ok(
    input int unsigned min_interval,
    input int unsigned interval_w,
    input int unsigned pos_w,
    input int unsigned pos_limit,
    input int unsigned max_tries
  );
    if (interval_w < 1 || interval_w > 15) return 1'b0;
    if (min_interval + (32'd1 << interval_w) - 1 > 32'h0000_FFFF) return 1'b0;
    if (pos_w < 1 || pos_w > 16) return 1'b0;
    if (pos_limit <= (32'd1 << (pos_w - 1)) || pos_limit > (32'd1 << pos_w)) return 1'b0;
    if (max_tries < 1) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/rand_range_sampler.sv
// rand_range_sampler: rejection-sampling helper for spawn positions.
//   clk, rst     - clock and synchronous active-high reset
//   start        - clear the attempt counter (new spawn round)
//   step         - count one rejected attempt
//   sample       - raw candidate bits (top bits of the random word)
//   cand_ok      - candidate is below POS_LIMIT
//   cand         - candidate position
//   fallback     - current attempt is the last one allowed
//   fallback_pos - candidate folded into range (cand - POS_LIMIT)
module rand_range_sampler #(
  parameter int unsigned POS_W     = 4,
  parameter int unsigned POS_LIMIT = 12,
  parameter int unsigned MAX_TRIES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [POS_W-1:0] sample,
  output logic             cand_ok,
  output logic [POS_W-1:0] cand,
  output logic             fallback,
  output logic [POS_W-1:0] fallback_pos
);

  localparam int unsigned        TRIES_W  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);
  // One extra bit so POS_LIMIT == 2^POS_W is representable.
  localparam logic [POS_W:0]     LIMIT    = (POS_W + 1)'(POS_LIMIT);

  logic [TRIES_W-1:0] tries;
  logic [POS_W:0]     folded;

  always_ff @(posedge clk) begin
    if (rst) begin
      tries <= '0;
    end else if (start) begin
      tries <= '0;
    end else if (step) begin
      tries <= tries + TRIES_W'(1);
    end
  end

  always_comb begin
    cand         = sample;
    cand_ok      = {1'b0, sample} < LIMIT;
    fallback     = (tries == LAST_TRY);
    folded       = {1'b0, sample} - LIMIT;
    fallback_pos = folded[POS_W-1:0];
  end

endmodule

// File: rtl/spawn_scheduler.sv
// spawn_scheduler: turns the free-running LFSR word into timed, bounded
// spawn events offered on a valid/ready handshake.
//   i_clk, i_rst  - clock, synchronous active-high reset
//   i_enable      - game running; arms the scheduler
//   i_rand_value  - random word, new value every cycle
//   o_spawn_valid - spawn offer valid (registered)
//   i_spawn_ready - downstream accepts the offer
//   o_spawn_pos   - spawn position, stable while o_spawn_valid is high
//   o_waiting     - high while the interval counter runs (registered)
module spawn_scheduler
  import spawn_pkg::*;
#(
  parameter logic [15:0] MIN_INTERVAL = 16'd32,
  parameter int unsigned INTERVAL_W   = 8,
  parameter int unsigned POS_W        = 4,
  parameter int unsigned POS_LIMIT    = 12,
  parameter int unsigned MAX_TRIES    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic [15:0]      i_rand_value,
  output logic             o_spawn_valid,
  input  logic             i_spawn_ready,
  output logic [POS_W-1:0] o_spawn_pos,
  output logic             o_waiting
);

  if (!params_ok(32'(MIN_INTERVAL), INTERVAL_W, POS_W, POS_LIMIT, MAX_TRIES)) begin : g_param_check
    $fatal(1, "spawn_scheduler: illegal parameter combination");
  end

  state_t           state;
  logic [15:0]      counter;
  logic [15:0]      load_value;
  logic             cand_ok;
  logic             fallback;
  logic [POS_W-1:0] cand;
  logic [POS_W-1:0] fallback_pos;
  logic             sampler_start;
  logic             sampler_step;
  logic             rand_unused;

  always_comb begin
    load_value    = MIN_INTERVAL + {{(16 - INTERVAL_W){1'b0}}, i_rand_value[INTERVAL_W-1:0]};
    sampler_start = (state == ST_LOAD);
    sampler_step  = (state == ST_PICK) && !cand_ok && !fallback;
    // Only the low interval bits and the top position bits are consumed.
    rand_unused   = ^i_rand_value;
  end

  rand_range_sampler #(
    .POS_W     (POS_W),
    .POS_LIMIT (POS_LIMIT),
    .MAX_TRIES (MAX_TRIES)
  ) u_sampler (
    .clk          (i_clk),
    .rst          (i_rst),
    .start        (sampler_start),
    .step         (sampler_step),
    .sample       (i_rand_value[15 -: POS_W]),
    .cand_ok      (cand_ok),
    .cand         (cand),
    .fallback     (fallback),
    .fallback_pos (fallback_pos)
  );

  // COUNT sees counter values N..0, so it lasts N+1 cycles before PICK.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      counter       <= '0;
      o_spawn_valid <= 1'b0;
      o_spawn_pos   <= '0;
      o_waiting     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_enable) state <= ST_LOAD;
        end
        ST_LOAD: begin
          counter   <= load_value;
          o_waiting <= 1'b1;
          state     <= ST_COUNT;
        end
        ST_COUNT: begin
          if (!i_enable) begin
            counter   <= '0;
            o_waiting <= 1'b0;
            state     <= ST_IDLE;
          end else if (counter == '0) begin
            o_waiting <= 1'b0;
            state     <= ST_PICK;
          end else begin
            counter <= counter - 16'd1;
          end
        end
        ST_PICK: begin
          if (cand_ok) begin
            o_spawn_pos   <= cand;
            o_spawn_valid <= 1'b1;
            state         <= ST_OFFER;
          end else if (fallback) begin
            o_spawn_pos   <= fallback_pos;
            o_spawn_valid <= 1'b1;
            state         <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (i_spawn_ready) begin
            o_spawn_valid <= 1'b0;
            state         <= i_enable ? ST_LOAD : ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spawn_scheduler.sv
// tb_spawn_scheduler: self-checking bench for spawn_scheduler with
// MIN_INTERVAL=4, INTERVAL_W=3, POS_W=4, POS_LIMIT=12, MAX_TRIES=4.
module tb_spawn_scheduler;

  localparam int MIN_IV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] rand_value;
  logic        spawn_ready;
  logic        spawn_valid;
  logic [3:0]  spawn_pos;
  logic        waiting;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] exp_q[$];

  spawn_scheduler #(
    .MIN_INTERVAL (16'd4),
    .INTERVAL_W   (3),
    .POS_W        (4),
    .POS_LIMIT    (12),
    .MAX_TRIES    (4)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_enable      (enable),
    .i_rand_value  (rand_value),
    .o_spawn_valid (spawn_valid),
    .i_spawn_ready (spawn_ready),
    .o_spawn_pos   (spawn_pos),
    .o_waiting     (waiting)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for COUNT to start, then returns how many cycles o_waiting stayed
  // high. Returns in the first PICK cycle.
  task automatic wait_pick(output int n_wait, output bit ok);
    int guard;
    guard  = 0;
    n_wait = 0;
    ok     = 1'b1;
    while (!waiting && guard < 10) begin
      step();
      guard++;
    end
    if (!waiting) begin
      ok = 1'b0;
      return;
    end
    while (waiting && n_wait < 300) begin
      step();
      n_wait++;
    end
    if (waiting) ok = 1'b0;
  endtask

  // Drives one PICK sample per cycle until the offer appears (bounded).
  task automatic drive_picks(input logic [15:0] s0, input logic [15:0] s1,
                             input logic [15:0] s2, input logic [15:0] s3,
                             output int picks);
    picks = 0;
    do begin
      case (picks)
        0:       rand_value = s0;
        1:       rand_value = s1;
        2:       rand_value = s2;
        default: rand_value = s3;
      endcase
      step();
      picks++;
    end while (!spawn_valid && picks < 8);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; spawn_ready = 1'b0; rand_value = '0;
    repeat (3) step();
    n_cmp++;
    if ({spawn_valid, spawn_pos, waiting} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_values: got v=%b p=%0d w=%b, expected v=0 p=0 w=0", spawn_valid, spawn_pos, waiting);
    end
    enable = 1'b1;
    repeat (3) step();
    n_cmp++;
    if ({spawn_valid, waiting} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_priority: got v=%b w=%b, expected v=0 w=0", spawn_valid, waiting);
    end
    enable = 1'b0;
    rst    = 1'b0;
    repeat (4) step();
    n_cmp++;
    if ({spawn_valid, waiting} !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_hold: got v=%b w=%b, expected v=0 w=0", spawn_valid, waiting);
    end
  endtask

  task automatic test_basic_timing();
    int lat;
    int n_wait;
    int picks;
    logic [3:0] exp;
    rand_value = 16'h0003;
    enable     = 1'b1;
    lat        = 0;
    while (!waiting && lat < 10) begin
      step();
      lat++;
    end
    n_cmp++;
    if (lat !== 2) begin
      n_bad++;
      $display("FAIL basic_load_latency: got %0d cycles, expected 2", lat);
    end
    n_wait = 0;
    while (waiting && n_wait < 300) begin
      step();
      n_wait++;
    end
    n_cmp++;
    if (n_wait !== MIN_IV + 3 + 1) begin
      n_bad++;
      $display("FAIL basic_wait_cycles: got %0d, expected %0d", n_wait, MIN_IV + 3 + 1);
    end
    exp_q.push_back(4'd5);
    drive_picks(16'h5000, 16'h5000, 16'h5000, 16'h5000, picks);
    n_cmp++;
    if (picks !== 1 || spawn_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_offer: got picks=%0d v=%b, expected picks=1 v=1", picks, spawn_valid);
    end
    exp = exp_q.pop_front();
    n_cmp++;
    if (spawn_pos !== exp) begin
      n_bad++;
      $display("FAIL basic_pos: got %0d, expected %0d", spawn_pos, exp);
    end
    spawn_ready = 1'b1;
    step();
    spawn_ready = 1'b0;
    n_cmp++;
    if (spawn_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_drop: got v=%b, expected 0", spawn_valid);
    end
  endtask

  task automatic test_rejection();
    int n_wait;
    int picks;
    bit ok;
    logic [3:0] exp;
    rand_value = 16'h0000;
    wait_pick(n_wait, ok);
    n_cmp++;
    if (!ok || n_wait !== MIN_IV + 0 + 1) begin
      n_bad++;
      $display("FAIL rej_wait_cycles: got %0d ok=%b, expected %0d", n_wait, ok, MIN_IV + 1);
    end
    exp_q.push_back(4'd3);
    drive_picks(16'hE000, 16'hD000, 16'h3000, 16'h3000, picks);
    n_cmp++;
    if (picks !== 3 || spawn_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rej_pick_count: got picks=%0d v=%b, expected picks=3 v=1", picks, spawn_valid);
    end
    exp = exp_q.pop_front();
    n_cmp++;
    if (spawn_pos !== exp) begin
      n_bad++;
      $display("FAIL rej_pos: got %0d, expected %0d", spawn_pos, exp);
    end
    spawn_ready = 1'b1;
    step();
    spawn_ready = 1'b0;
  endtask

  task automatic test_fallback();
    int n_wait;
    int picks;
    bit ok;
    logic [3:0] exp;
    rand_value = 16'h0002;
    wait_pick(n_wait, ok);
    n_cmp++;
    if (!ok || n_wait !== MIN_IV + 2 + 1) begin
      n_bad++;
      $display("FAIL fb_wait_cycles: got %0d ok=%b, expected %0d", n_wait, ok, MIN_IV + 3);
    end
    exp_q.push_back(4'd2);
    drive_picks(16'hF000, 16'hC000, 16'hD000, 16'hE000, picks);
    n_cmp++;
    if (picks !== 4 || spawn_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL fb_pick_count: got picks=%0d v=%b, expected picks=4 v=1", picks, spawn_valid);
    end
    exp = exp_q.pop_front();
    n_cmp++;
    if (spawn_pos !== exp) begin
      n_bad++;
      $display("FAIL fb_pos: got %0d, expected %0d", spawn_pos, exp);
    end
  endtask

  // Entered with an offer of position 2 pending.
  task automatic test_backpressure();
    spawn_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_value = 16'(i * 16'h1357);
      step();
      n_cmp++;
      if (spawn_valid !== 1'b1 || spawn_pos !== 4'd2) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got v=%b p=%0d, expected v=1 p=2", i, spawn_valid, spawn_pos);
      end
    end
    rand_value  = 16'h0007;
    spawn_ready = 1'b1;
    step();
    spawn_ready = 1'b0;
    n_cmp++;
    if (spawn_valid !== 1'b0 || waiting !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_transfer: got v=%b w=%b, expected v=0 w=0", spawn_valid, waiting);
    end
    step();
    n_cmp++;
    if (waiting !== 1'b1 || spawn_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_reload: got w=%b v=%b, expected w=1 v=0", waiting, spawn_valid);
    end
  endtask

  // Entered in the first COUNT cycle of an N=11 interval.
  task automatic test_enable();
    int n_wait;
    int picks;
    bit ok;
    logic [3:0] exp;
    step();
    step();
    enable = 1'b0;
    step();
    n_cmp++;
    if (waiting !== 1'b0) begin
      n_bad++;
      $display("FAIL en_count_abort: got w=%b, expected 0", waiting);
    end
    for (int i = 0; i < 15; i++) begin
      step();
      n_cmp++;
      if (spawn_valid !== 1'b0 || waiting !== 1'b0) begin
        n_bad++;
        $display("FAIL en_no_spawn[%0d]: got v=%b w=%b, expected v=0 w=0", i, spawn_valid, waiting);
      end
    end
    enable     = 1'b1;
    rand_value = 16'h0001;
    wait_pick(n_wait, ok);
    n_cmp++;
    if (!ok || n_wait !== MIN_IV + 1 + 1) begin
      n_bad++;
      $display("FAIL en_wait_cycles: got %0d ok=%b, expected %0d", n_wait, ok, MIN_IV + 2);
    end
    exp_q.push_back(4'd10);
    drive_picks(16'hA000, 16'hA000, 16'hA000, 16'hA000, picks);
    exp = exp_q.pop_front();
    n_cmp++;
    if (spawn_valid !== 1'b1 || spawn_pos !== exp) begin
      n_bad++;
      $display("FAIL en_pos: got v=%b p=%0d, expected v=1 p=%0d", spawn_valid, spawn_pos, exp);
    end
    enable = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (spawn_valid !== 1'b1 || spawn_pos !== exp) begin
      n_bad++;
      $display("FAIL en_offer_held: got v=%b p=%0d, expected v=1 p=%0d", spawn_valid, spawn_pos, exp);
    end
    spawn_ready = 1'b1;
    step();
    spawn_ready = 1'b0;
    n_cmp++;
    if (spawn_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL en_offer_taken: got v=%b, expected 0", spawn_valid);
    end
    repeat (6) step();
    n_cmp++;
    if (waiting !== 1'b0 || spawn_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL en_no_reload: got w=%b v=%b, expected w=0 v=0", waiting, spawn_valid);
    end
  endtask

  task automatic test_reset_in_offer();
    int n_wait;
    int picks;
    bit ok;
    logic [3:0] exp;
    enable     = 1'b1;
    rand_value = 16'h0000;
    wait_pick(n_wait, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL rio_wait: timeout waiting for PICK, got ok=%b expected 1", ok);
    end
    exp_q.push_back(4'd11);
    drive_picks(16'hB000, 16'hB000, 16'hB000, 16'hB000, picks);
    exp = exp_q.pop_front();
    n_cmp++;
    if (spawn_valid !== 1'b1 || spawn_pos !== exp) begin
      n_bad++;
      $display("FAIL rio_pos: got v=%b p=%0d, expected v=1 p=%0d", spawn_valid, spawn_pos, exp);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({spawn_valid, spawn_pos, waiting} !== 6'b0) begin
      n_bad++;
      $display("FAIL rio_reset: got v=%b p=%0d w=%b, expected v=0 p=0 w=0", spawn_valid, spawn_pos, waiting);
    end
    step();
    n_cmp++;
    if (waiting !== 1'b0) begin
      n_bad++;
      $display("FAIL rio_load_cycle: got w=%b, expected 0", waiting);
    end
    step();
    n_cmp++;
    if (waiting !== 1'b1) begin
      n_bad++;
      $display("FAIL rio_count_start: got w=%b, expected 1", waiting);
    end
    enable = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic_timing();
    test_rejection();
    test_fallback();
    test_backpressure();
    test_enable();
    test_reset_in_offer();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
